// File: rtl/finv_sched.sv
// rtl/finv_sched.sv - round-robin scheduler sharing one pipelined finv unit between two requesters
// Optional perf counters enabled by defining FINV_SCHED_PERF_EN.
module finv_sched #(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    input  logic [31:0] req0_x,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_x,
    output logic        req1_ready,
    output logic [31:0] fu_x,
    input  logic [31:0] fu_y,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_y,
`ifdef FINV_SCHED_PERF_EN
    output logic [31:0] perf_issue,
    output logic [31:0] perf_stall0,
    output logic [31:0] perf_stall1,
`endif
    output logic        busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic               r_rr;
    logic [LATENCY-1:0] r_pv;
    logic [LATENCY-1:0] r_pid;
    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      r_count;
    logic [AW-1:0]      r_wr;
    logic [AW-1:0]      r_rd;
    logic [32:0]        r_mem [FIFO_DEPTH];

    logic               w_credit;
    logic               w_g0;
    logic               w_g1;
    logic               w_issue;
    logic               w_cap;
    logic               w_pop;
    logic               w_empty;
    logic [CW-1:0]      w_cnt;

    // Credits cover both in-flight ops and stored results, so a capture can never overflow.
    assign w_cnt    = r_inflight + r_count;
    assign w_credit = rstn & (w_cnt < DEPTH_C);
    assign w_g0     = w_credit & req0_valid & (~req1_valid | ~r_rr);
    assign w_g1     = w_credit & req1_valid & (~req0_valid | r_rr);
    assign w_issue  = w_g0 | w_g1;
    assign w_cap    = r_pv[LATENCY-1];
    assign w_empty  = (r_count == '0);
    assign w_pop    = ~w_empty & resp_ready;

    assign req0_ready = w_g0;
    assign req1_ready = w_g1;
    assign fu_x       = w_g0 ? req0_x : (w_g1 ? req1_x : 32'h0);
    assign resp_valid = ~w_empty;
    assign resp_id    = w_empty ? 1'b0 : r_mem[r_rd][32];
    assign resp_y     = w_empty ? 32'h0 : r_mem[r_rd][31:0];
    assign busy       = (r_inflight != '0) | ~w_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr       <= 1'b0;
            r_pv       <= '0;
            r_pid      <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
        end else begin
            if (req0_valid & req1_valid & w_credit) begin
                r_rr <= ~r_rr;
            end
            r_pv[0]  <= w_issue;
            r_pid[0] <= w_g1;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pid[i] <= r_pid[i-1];
            end
            case ({w_issue, w_cap})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            case ({w_cap, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_cap) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_mem[r_wr] <= {r_pid[LATENCY-1], fu_y};
        end
    end

`ifdef FINV_SCHED_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall0;
    logic [31:0] r_perf_stall1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_issue  <= '0;
            r_perf_stall0 <= '0;
            r_perf_stall1 <= '0;
        end else begin
            if (w_issue) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
            if (req0_valid & ~w_g0) begin
                r_perf_stall0 <= r_perf_stall0 + 32'd1;
            end
            if (req1_valid & ~w_g1) begin
                r_perf_stall1 <= r_perf_stall1 + 32'd1;
            end
        end
    end

    assign perf_issue  = r_perf_issue;
    assign perf_stall0 = r_perf_stall0;
    assign perf_stall1 = r_perf_stall1;
`endif

endmodule
